// File: rtl/flop_mult_arbiter_if.sv
// Requester, multiplier and response signals around flop_mult_arbiter.
// The arbiter uses the slave modport; clients and the multiplier model use master.
interface flop_mult_arbiter_if;
  logic        req0_valid;
  logic [12:0] req0_a;
  logic [12:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [12:0] req1_a;
  logic [12:0] req1_b;
  logic        req1_ready;
  logic [12:0] mul_one;
  logic [12:0] mul_other;
  logic [12:0] mul_result;
  logic        rsp_valid;
  logic        rsp_id;
  logic [12:0] rsp_result;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_result, rsp_ready,
    output req0_ready, req1_ready, mul_one, mul_other, rsp_valid, rsp_id, rsp_result,
           busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_result, rsp_ready,
    input  req0_ready, req1_ready, mul_one, mul_other, rsp_valid, rsp_id, rsp_result,
           busy, op_count
  );
endinterface

// File: rtl/flop_mult_arbiter.sv
// Shares one combinational 13-bit float multiplier between two requesters:
// registers the granted operands, waits CALC_CYCLES, returns the tagged product.
module flop_mult_arbiter #(
  parameter int unsigned CALC_CYCLES = 1  // legal 1..15
) (
  input logic                clk,
  input logic                rst_n,
  flop_mult_arbiter_if.slave bus
);

  localparam logic [3:0] CALC_LOAD = 4'(CALC_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state,      w_state_nxt;
  logic [3:0]  r_cnt,        w_cnt_nxt;
  logic [12:0] r_mul_one,    w_mul_one_nxt;
  logic [12:0] r_mul_other,  w_mul_other_nxt;
  logic [12:0] r_rsp_result, w_rsp_result_nxt;
  logic        r_rsp_valid,  w_rsp_valid_nxt;
  logic        r_rsp_id,     w_rsp_id_nxt;
  logic        r_last_grant, w_last_grant_nxt;
  logic [15:0] r_op_count,   w_op_count_nxt;

  logic w_idle;
  logic w_grant;
  logic w_accept;

  assign w_idle = (r_state == ST_IDLE);

  // A lone requester always wins; on a tie the one that did not win last time goes.
  assign w_grant = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;

  assign bus.req0_ready = w_idle && !w_grant;
  assign bus.req1_ready = w_idle && w_grant;

  assign w_accept = w_grant ? (bus.req1_valid && bus.req1_ready)
                            : (bus.req0_valid && bus.req0_ready);

  // NOTE: every signal written here gets its hold value first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_mul_one_nxt    = r_mul_one;
    w_mul_other_nxt  = r_mul_other;
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_id_nxt     = r_rsp_id;
    w_last_grant_nxt = r_last_grant;
    w_op_count_nxt   = r_op_count;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_mul_one_nxt    = w_grant ? bus.req1_a : bus.req0_a;
          w_mul_other_nxt  = w_grant ? bus.req1_b : bus.req0_b;
          w_rsp_id_nxt     = w_grant;
          w_last_grant_nxt = w_grant;
          w_cnt_nxt        = CALC_LOAD;
          w_state_nxt      = ST_CALC;
        end
      end
      ST_CALC: begin
        // Operands have been stable for CALC_CYCLES edges once cnt reaches 1.
        if (r_cnt == 4'd1) begin
          w_rsp_result_nxt = bus.mul_result;
          w_rsp_valid_nxt  = 1'b1;
          w_state_nxt      = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_op_count_nxt  = r_op_count + 16'd1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_mul_one    <= 13'd0;
      r_mul_other  <= 13'd0;
      r_rsp_result <= 13'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_last_grant <= 1'b1;
      r_op_count   <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mul_one    <= w_mul_one_nxt;
      r_mul_other  <= w_mul_other_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_id     <= w_rsp_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_op_count   <= w_op_count_nxt;
    end
  end

  assign bus.mul_one    = r_mul_one;
  assign bus.mul_other  = r_mul_other;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.busy       = !w_idle;
  assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_flop_mult_arbiter.sv
// Randomized bench for flop_mult_arbiter: one instance with a 1-cycle settle time,
// one with a 4-cycle settle time, checked against a transaction-level model.
module tb_flop_mult_arbiter;
  localparam time T  = 10;
  localparam int  C1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #(T / 2) clk = ~clk;

  flop_mult_arbiter_if if1 ();
  flop_mult_arbiter_if if4 ();

  flop_mult_arbiter #(.CALC_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  flop_mult_arbiter #(.CALC_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in multiplier for dut1: any fixed function of the operands will do.
  function automatic logic [12:0] fake_mul(input logic [12:0] x, input logic [12:0] y);
    return (x ^ {y[5:0], y[12:6]}) + 13'd7;
  endfunction

  logic        use_fake;
  logic [12:0] drv_result;
  assign if1.mul_result = use_fake ? fake_mul(if1.mul_one, if1.mul_other) : drv_result;

  // Transaction-level model state.
  bit          m_last;
  logic [15:0] m_ops;

  task automatic drop_requests();
    if1.req0_valid = 1'b0;
    if1.req1_valid = 1'b0;
    if4.req0_valid = 1'b0;
    if4.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drop_requests();
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b1;
    m_ops  = 16'd0;
  endtask

  // One full transaction on dut1, starting and ending at a falling edge.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [12:0] a0, input logic [12:0] b0,
                         input logic [12:0] a1, input logic [12:0] b1,
                         input int bp, output int acc_cyc);
    bit          g;
    logic [12:0] ea, eb, er;
    int          k;
    if1.req0_valid = v0; if1.req0_a = a0; if1.req0_b = b0;
    if1.req1_valid = v1; if1.req1_a = a1; if1.req1_b = b1;
    if1.rsp_ready  = (bp == 0);
    g  = (v0 && v1) ? !m_last : v1;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    er = use_fake ? fake_mul(ea, eb) : drv_result;
    #1;
    n_checks++; if (if1.req0_ready !== !g) $display("FAIL grant_req0_ready: got %b want %b", if1.req0_ready, !g); else n_pass++;
    n_checks++; if (if1.req1_ready !== g) $display("FAIL grant_req1_ready: got %b want %b", if1.req1_ready, g); else n_pass++;
    n_checks++; if (if1.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", if1.busy); else n_pass++;
    acc_cyc = cyc;
    m_last  = g;
    @(negedge clk);
    k = 1;
    while (if1.rsp_valid !== 1'b1 && k <= 20) begin
      n_checks++; if (if1.busy !== 1'b1) $display("FAIL calc_busy: got %b want 1", if1.busy); else n_pass++;
      n_checks++; if (if1.mul_one !== ea) $display("FAIL calc_mul_one: got %h want %h", if1.mul_one, ea); else n_pass++;
      n_checks++; if (if1.mul_other !== eb) $display("FAIL calc_mul_other: got %h want %h", if1.mul_other, eb); else n_pass++;
      n_checks++; if ({if1.req0_ready, if1.req1_ready} !== 2'b00) $display("FAIL calc_ready: got %b want 00", {if1.req0_ready, if1.req1_ready}); else n_pass++;
      @(negedge clk);
      k++;
    end
    n_checks++; if (if1.rsp_valid !== 1'b1) $display("FAIL rsp_timeout: rsp_valid got %b want 1", if1.rsp_valid); else n_pass++;
    n_checks++; if (k != C1 + 1) $display("FAIL rsp_latency: got %0d want %0d", k, C1 + 1); else n_pass++;
    n_checks++; if (if1.rsp_id !== g) $display("FAIL rsp_id: got %b want %b", if1.rsp_id, g); else n_pass++;
    n_checks++; if (if1.rsp_result !== er) $display("FAIL rsp_result: got %h want %h", if1.rsp_result, er); else n_pass++;
    repeat (bp) begin
      @(negedge clk);
      n_checks++; if (if1.rsp_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", if1.rsp_valid); else n_pass++;
      n_checks++; if (if1.rsp_result !== er) $display("FAIL bp_result: got %h want %h", if1.rsp_result, er); else n_pass++;
      n_checks++; if (if1.rsp_id !== g) $display("FAIL bp_id: got %b want %b", if1.rsp_id, g); else n_pass++;
      n_checks++; if (if1.mul_one !== ea) $display("FAIL bp_mul_one: got %h want %h", if1.mul_one, ea); else n_pass++;
      n_checks++; if ({if1.req0_ready, if1.req1_ready, if1.busy} !== 3'b001) $display("FAIL bp_ready_busy: got %b want 001", {if1.req0_ready, if1.req1_ready, if1.busy}); else n_pass++;
    end
    if1.rsp_ready = 1'b1;
    @(negedge clk);
    m_ops++;
    n_checks++; if (if1.rsp_valid !== 1'b0) $display("FAIL done_valid: got %b want 0", if1.rsp_valid); else n_pass++;
    n_checks++; if (if1.op_count !== m_ops) $display("FAIL op_count: got %h want %h", if1.op_count, m_ops); else n_pass++;
    n_checks++; if (if1.busy !== 1'b0) $display("FAIL done_busy: got %b want 0", if1.busy); else n_pass++;
    drop_requests();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drop_requests();
    if1.rsp_ready = 1'b0; if4.rsp_ready = 1'b0;
    if1.req0_a = '0; if1.req0_b = '0; if1.req1_a = '0; if1.req1_b = '0;
    if4.req0_a = '0; if4.req0_b = '0; if4.req1_a = '0; if4.req1_b = '0;
    if4.mul_result = '0;
    use_fake = 1'b1; drv_result = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (if1.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", if1.rsp_valid); else n_pass++;
    n_checks++; if (if1.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", if1.busy); else n_pass++;
    n_checks++; if (if1.op_count !== 16'd0) $display("FAIL rst_op_count: got %h want 0", if1.op_count); else n_pass++;
    n_checks++; if ({if1.mul_one, if1.mul_other} !== 26'd0) $display("FAIL rst_mul: got %h want 0", {if1.mul_one, if1.mul_other}); else n_pass++;
    n_checks++; if ({if1.rsp_id, if1.rsp_result} !== 14'd0) $display("FAIL rst_rsp: got %h want 0", {if1.rsp_id, if1.rsp_result}); else n_pass++;
    n_checks++; if (if4.busy !== 1'b0) $display("FAIL rst_busy4: got %b want 0", if4.busy); else n_pass++;
    rst_n  = 1'b1;
    m_last = 1'b1;
    m_ops  = 16'd0;
  endtask

  task automatic test_single();
    int t;
    use_fake   = 1'b0;
    drv_result = 13'h0F0F;
    run_txn(1'b1, 1'b0, 13'h0A12, 13'h1043, 13'h0, 13'h0, 0, t);
    use_fake = 1'b1;
  endtask

  task automatic test_fairness();
    int t_prev, t_now;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (m_last !== ((i % 2) == 0)) $display("FAIL tie_order: step %0d expected winner %0d", i, i % 2); else n_pass++;
      run_txn(1'b1, 1'b1, 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom), 0, t_now);
      if (i > 0) begin
        n_checks++; if (t_now - t_prev != C1 + 2) $display("FAIL tie_period: got %0d want %0d", t_now - t_prev, C1 + 2); else n_pass++;
      end
      t_prev = t_now;
    end
    n_checks++; if (if1.op_count !== 16'd4) $display("FAIL tie_op_count: got %h want 4", if1.op_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    int t;
    run_txn(1'b1, 1'b1, 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom), 5, t);
  endtask

  task automatic test_settle();
    logic [12:0] a, b;
    a = 13'($urandom); b = 13'($urandom);
    @(negedge clk);
    if4.req1_valid = 1'b1; if4.req1_a = a; if4.req1_b = b;
    if4.rsp_ready  = 1'b1;
    if4.mul_result = 13'h0000;
    #1;
    n_checks++; if ({if4.req0_ready, if4.req1_ready} !== 2'b01) $display("FAIL settle_ready: got %b want 01", {if4.req0_ready, if4.req1_ready}); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if4.req1_valid = 1'b0;
      n_checks++; if (if4.rsp_valid !== (k == 5)) $display("FAIL settle_valid: cycle %0d got %b want %b", k, if4.rsp_valid, k == 5); else n_pass++;
      if (k < 5) begin
        n_checks++; if ({if4.mul_one, if4.mul_other} !== {a, b}) $display("FAIL settle_mul: got %h want %h", {if4.mul_one, if4.mul_other}, {a, b}); else n_pass++;
      end
      if4.mul_result = 13'(k);
    end
    n_checks++; if (if4.rsp_result !== 13'h0004) $display("FAIL settle_result: got %h want 0004", if4.rsp_result); else n_pass++;
    n_checks++; if (if4.rsp_id !== 1'b1) $display("FAIL settle_id: got %b want 1", if4.rsp_id); else n_pass++;
    @(negedge clk);
    n_checks++; if ({if4.rsp_valid, if4.op_count} !== {1'b0, 16'd1}) $display("FAIL settle_done: got %h want 00001", {if4.rsp_valid, if4.op_count}); else n_pass++;
  endtask

  task automatic test_random();
    bit v0, v1;
    int t;
    for (int i = 0; i < 20; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      run_txn(v0, v1, 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom),
              int'($urandom_range(0, 3)), t);
    end
  endtask

  task automatic test_reset_mid_calc();
    int t;
    if1.req0_valid = 1'b1; if1.req0_a = 13'($urandom) | 13'd1; if1.req0_b = 13'($urandom);
    @(negedge clk);
    drop_requests();
    n_checks++; if (if1.busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b want 1", if1.busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({if1.rsp_valid, if1.busy} !== 2'b00) $display("FAIL midrst_valid_busy: got %b want 00", {if1.rsp_valid, if1.busy}); else n_pass++;
    n_checks++; if (if1.mul_one !== 13'd0) $display("FAIL midrst_mul_one: got %h want 0", if1.mul_one); else n_pass++;
    n_checks++; if (if1.op_count !== 16'd0) $display("FAIL midrst_op_count: got %h want 0", if1.op_count); else n_pass++;
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b1;
    m_ops  = 16'd0;
    run_txn(1'b0, 1'b1, 13'h0, 13'h0, 13'($urandom), 13'($urandom), 0, t);
  endtask

  task automatic test_wrap();
    int t;
    @(negedge clk);
    force dut1.r_op_count = 16'hFFFF;
    #1 release dut1.r_op_count;
    n_checks++; if (if1.op_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h want ffff", if1.op_count); else n_pass++;
    m_ops = 16'hFFFF;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 13'($urandom), 13'($urandom), 13'h0, 13'h0, 1, t);
  endtask

  initial begin
    #(T * 20000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_settle();
    test_random();
    test_reset_mid_calc();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
